hub_bus_arbiter: RTL and testbench

Round-robin arbiter that shares the hub's single 4-bit output nibble and response path among up to four Arduino nodes. Each node raises a nonzero 2-bit request code. The arbiter grants one node at a time and drives `{address, code}` on the shared nibble. It returns the code to the granted node for a fixed number of ticks, then releases the bus. It sits between the per-node request lines and the hub display/output logic, and is paced by the `temporizador` divided tick.

---
 rtl/hub_bus_arbiter.sv | 130 +++++++++++++
 tb/tb_hub_bus_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/hub_bus_arbiter.sv
// hub_bus_arbiter: round-robin owner of the hub's shared output nibble.
// One node at a time gets the bus, sees its code echoed back, then lets go.
//
// Ports:
//   clock50         system clock, rising edge
//   reset           synchronous, active-high
//   tick            one-cycle enable from temporizador; the FSM moves only then
//   req_code        2 bits per node, 00 = idle
//   grant           one-hot grant
//   arduinoResponse per-node echo of the latched code
//   out             {addr, code} of the active transaction
//   responseDisplay nibble of the last completed transaction
//   busy            high whenever the FSM is not idle
module hub_bus_arbiter #(
    parameter int NODES      = 4,
    parameter int HOLD_TICKS = 3
) (
    input  logic               clock50,
    input  logic               reset,
    input  logic               tick,
    input  logic [2*NODES-1:0] req_code,
    output logic [NODES-1:0]   grant,
    output logic [2*NODES-1:0] arduinoResponse,
    output logic [3:0]         out,
    output logic [3:0]         responseDisplay,
    output logic               busy
);

    localparam int RW = 2 * NODES;

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_RESPOND,
        S_RELEASE
    } state_t;

    state_t     r_state;
    logic [1:0] r_last;
    logic [1:0] r_addr;
    logic [1:0] r_code;
    logic [3:0] r_cnt;

    logic       w_found;
    logic [1:0] w_sel;
    logic [1:0] w_live;

    // Search from last+1 upward. The loop runs from the farthest offset
    // down to the nearest, so the nearest requester wins.
    always_comb begin
        int idx;
        idx     = 0;
        w_found = 1'b0;
        w_sel   = 2'd0;
        for (int k = NODES; k >= 1; k--) begin
            idx = (int'(r_last) + k) % NODES;
            if (req_code[2*idx +: 2] != 2'b00) begin
                w_found = 1'b1;
                w_sel   = idx[1:0];
            end
        end
    end

    // Live code of the granted node, used only for the abort test.
    always_comb begin
        w_live = req_code[2*int'(r_addr) +: 2];
    end

    always_ff @(posedge clock50) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_last          <= 2'(NODES - 1);
            r_addr          <= 2'd0;
            r_code          <= 2'd0;
            r_cnt           <= 4'd0;
            grant           <= '0;
            arduinoResponse <= '0;
            out             <= 4'd0;
            responseDisplay <= 4'd0;
            busy            <= 1'b0;
        end else if (tick) begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_addr  <= w_sel;
                        r_code  <= req_code[2*int'(w_sel) +: 2];
                        grant   <= NODES'(1) << w_sel;
                        out     <= {w_sel, req_code[2*int'(w_sel) +: 2]};
                        busy    <= 1'b1;
                        r_state <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (w_live == 2'b00) begin
                        // Requester withdrew: give the bus back unanswered.
                        grant   <= '0;
                        out     <= 4'd0;
                        r_state <= S_RELEASE;
                    end else begin
                        arduinoResponse <= RW'(r_code) << {r_addr, 1'b0};
                        r_cnt           <= 4'(HOLD_TICKS - 1);
                        r_state         <= S_RESPOND;
                    end
                end
                S_RESPOND: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        arduinoResponse <= '0;
                        grant           <= '0;
                        out             <= 4'd0;
                        responseDisplay <= {r_addr, r_code};
                        r_state         <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    // Aborted owners also move the pointer, so they lose
                    // priority exactly as if they had been served.
                    r_last  <= r_addr;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hub_bus_arbiter.sv
// tb_hub_bus_arbiter: directed stimulus with a scoreboard queue.
// Each tick pushes the expected output snapshot; a monitor pops and compares.
module tb_hub_bus_arbiter;

    logic       clock50 = 1'b0;
    logic       reset;
    logic       tick;
    logic [7:0] req_code;
    logic [3:0] grant;
    logic [7:0] arduinoResponse;
    logic [3:0] out;
    logic [3:0] responseDisplay;
    logic       busy;

    hub_bus_arbiter #(
        .NODES      (4),
        .HOLD_TICKS (3)
    ) dut (
        .clock50         (clock50),
        .reset           (reset),
        .tick            (tick),
        .req_code        (req_code),
        .grant           (grant),
        .arduinoResponse (arduinoResponse),
        .out             (out),
        .responseDisplay (responseDisplay),
        .busy            (busy)
    );

    always #5 clock50 = ~clock50;

    int          checks   = 0;
    int          failures = 0;
    string       phase    = "init";
    logic [20:0] q[$];
    logic        s_tick   = 1'b0;
    logic        s_rst    = 1'b0;

    function automatic logic [20:0] snap(input logic [3:0] g,
                                         input logic [3:0] o,
                                         input logic [7:0] r,
                                         input logic [3:0] d,
                                         input logic b);
        return {g, o, r, d, b};
    endfunction

    always @(posedge clock50) begin
        s_tick <= tick;
        s_rst  <= reset;
    end

    always @(negedge clock50) begin
        logic [20:0] act;
        logic [20:0] exp;
        act = {grant, out, arduinoResponse, responseDisplay, busy};
        if (s_rst) begin
            checks++;
            if (act !== 21'd0) begin
                failures++;
                $display("FAIL %s reset: got g=%b o=%b r=%h d=%b b=%b want all 0",
                         phase, grant, out, arduinoResponse,
                         responseDisplay, busy);
            end
        end else if (s_tick) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL %s scoreboard empty: got %h want a queued entry",
                         phase, act);
            end else begin
                exp = q.pop_front();
                if (act !== exp) begin
                    failures++;
                    $display("FAIL %s: got g=%b o=%b r=%h d=%b b=%b want g=%b o=%b r=%h d=%b b=%b",
                             phase, grant, out, arduinoResponse,
                             responseDisplay, busy,
                             exp[20:17], exp[16:13], exp[12:5],
                             exp[4:1], exp[0]);
                end
            end
        end
    end

    task automatic tk(input logic [7:0] rq, input logic [20:0] e);
        req_code = rq;
        tick     = 1'b1;
        q.push_back(e);
        @(posedge clock50);
        #1 tick = 1'b0;
        @(posedge clock50);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset    = 1'b1;
        tick     = 1'b0;
        req_code = 8'h00;
        repeat (n) @(posedge clock50);
        #1 reset = 1'b0;
        @(posedge clock50);
        #1;
    endtask

    // Full transaction: IDLE tick, GRANT tick, three hold ticks,
    // release tick. ra drives the first two ticks, rb the rest.
    task automatic txn(input logic [7:0] ra, input logic [7:0] rb,
                       input logic [3:0] g, input logic [3:0] o,
                       input logic [7:0] r, input logic [3:0] pd);
        tk(ra, snap(g, o, 8'h00, pd, 1'b1));
        tk(ra, snap(g, o, r, pd, 1'b1));
        tk(rb, snap(g, o, r, pd, 1'b1));
        tk(rb, snap(g, o, r, pd, 1'b1));
        tk(rb, snap(4'd0, 4'd0, 8'h00, o, 1'b1));
        tk(rb, snap(4'd0, 4'd0, 8'h00, o, 1'b0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        tick     = 1'b0;
        req_code = 8'h00;
        @(posedge clock50);
        #1;

        phase = "reset_idle";
        do_reset(2);
        for (int i = 0; i < 10; i++) begin
            tk(8'h00, 21'd0);
        end

        phase = "single_n2";
        txn(8'h30, 8'h30, 4'b0100, 4'b1011, 8'h30, 4'b0000);
        tk(8'h00, snap(4'd0, 4'd0, 8'h00, 4'b1011, 1'b0));

        phase = "round_robin";
        do_reset(1);
        txn(8'h55, 8'h55, 4'b0001, 4'b0001, 8'h01, 4'b0000);
        txn(8'h55, 8'h55, 4'b0010, 4'b0101, 8'h04, 4'b0001);
        txn(8'h55, 8'h55, 4'b0100, 4'b1001, 8'h10, 4'b0101);
        txn(8'h55, 8'h55, 4'b1000, 4'b1101, 8'h40, 4'b1001);
        txn(8'h55, 8'h55, 4'b0001, 4'b0001, 8'h01, 4'b1101);

        phase = "abort_n1";
        tk(8'h08, snap(4'b0010, 4'b0110, 8'h00, 4'b0001, 1'b1));
        tk(8'h00, snap(4'd0, 4'd0, 8'h00, 4'b0001, 1'b1));
        tk(8'h00, snap(4'd0, 4'd0, 8'h00, 4'b0001, 1'b0));

        phase = "after_abort_n0";
        txn(8'h06, 8'h06, 4'b0001, 4'b0010, 8'h02, 4'b0001);

        phase = "code_change_n3";
        txn(8'h40, 8'h80, 4'b1000, 4'b1101, 8'h40, 4'b0010);

        phase = "reset_mid";
        tk(8'h10, snap(4'b0100, 4'b1001, 8'h00, 4'b1101, 1'b1));
        tk(8'h10, snap(4'b0100, 4'b1001, 8'h10, 4'b1101, 1'b1));
        tk(8'h10, snap(4'b0100, 4'b1001, 8'h10, 4'b1101, 1'b1));
        reset    = 1'b1;
        tick     = 1'b1;
        req_code = 8'h10;
        @(posedge clock50);
        #1 reset = 1'b0;
        tick     = 1'b0;
        req_code = 8'h00;
        @(posedge clock50);
        #1;

        phase = "post_reset_n3";
        txn(8'h80, 8'h80, 4'b1000, 4'b1110, 8'h80, 4'b0000);

        phase = "post_reset_rr";
        txn(8'h41, 8'h41, 4'b0001, 4'b0001, 8'h01, 4'b1110);

        repeat (3) @(posedge clock50);
        #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d entries left want 0", q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
